// File: rtl/uart_tx_fifo_if.sv
// Producer-side handshake for the FIFO-fronted UART transmitter.
// The producer holds P_DATA/DATA_VALID until a cycle with READY high.
interface uart_tx_fifo_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  READY;

   modport master (output P_DATA, output DATA_VALID, input READY);
   modport slave  (input P_DATA, input DATA_VALID, output READY);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO, bit-period prescaler,
// optional parity and 1/2 stop bits; queued frames are sent back-to-back.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PRESC_W    = 6
) (
   input  logic                              CLK,
   input  logic                              RST,
   uart_tx_fifo_if.slave                     bus,
   input  logic                              PAR_EN,
   input  logic                              PAR_TYP,
   input  logic                              STOP2,
   input  logic [PRESC_W-1:0]                PRESCALE,
   output logic                              TX_OUT,
   output logic                              BUSY,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BIT_W = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------- FIFO ----------------
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head;

   // READY looks at the registered count only, so a same-cycle pop never frees a slot early.
   assign bus.READY  = (count < CNT_W'(FIFO_DEPTH));
   assign push       = bus.DATA_VALID && bus.READY;
   assign head       = mem[rd_ptr];
   assign FIFO_COUNT = count;

   // NOTE: storage array has no reset; occupancy is tracked by count, so stale words are never read.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr] <= bus.P_DATA;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------- Serialiser ----------------
   state_t                state_q, state_d;
   logic [PRESC_W-1:0]    timer_q, timer_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  shift_en;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [PRESC_W-1:0]    period_q;
   logic                  par_en_q;
   logic                  stop2_q;
   logic                  par_bit_q;
   logic                  last_tick;
   logic                  fifo_nonempty;

   assign last_tick     = (timer_q == period_q - 1'b1);
   assign fifo_nonempty = (count != '0);

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + 1'b1;
      bit_d    = bit_q;
      stop_d   = stop_q;
      tx_d     = tx_q;
      busy_d   = 1'b1;
      pop      = 1'b0;
      shift_en = 1'b0;

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            if (fifo_nonempty) begin
               pop     = 1'b1;
               state_d = S_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (last_tick) begin
               timer_d = '0;
               bit_d   = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (last_tick) begin
               timer_d = '0;
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                  stop_d = 1'b0;
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d    = bit_q + 1'b1;
                  shift_en = 1'b1;
                  tx_d     = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (last_tick) begin
               timer_d = '0;
               stop_d  = 1'b0;
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (last_tick) begin
               timer_d = '0;
               if (stop2_q && !stop_q) begin
                  stop_d = 1'b1;
               end else if (fifo_nonempty) begin
                  // Chain straight into the next start bit with no idle cycle.
                  pop     = 1'b1;
                  state_d = S_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_q     <= '0;
         stop_q    <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         shift_q   <= '0;
         period_q  <= PRESC_W'(1);
         par_en_q  <= 1'b0;
         stop2_q   <= 1'b0;
         par_bit_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         // Frame configuration is captured only when a word is popped.
         if (pop) begin
            shift_q   <= head;
            period_q  <= (PRESCALE == '0) ? PRESC_W'(1) : PRESCALE;
            par_en_q  <= PAR_EN;
            stop2_q   <= STOP2;
            par_bit_q <= (^head) ^ PAR_TYP;
         end else if (shift_en) begin
            shift_q   <= shift_q >> 1;
         end
      end
   end

   assign TX_OUT = tx_q;
   assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: table-driven single frames
// plus hand-written reset, back-to-back, config-change and pointer-wrap sequences.
module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int PW    = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic          STOP2;
   logic [PW-1:0] PRESCALE;
   logic          TX_OUT;
   logic          BUSY;
   logic [2:0]    FIFO_COUNT;

   uart_tx_fifo_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_fifo #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .PRESC_W    (PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .bus        (bus.slave),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .STOP2      (STOP2),
      .PRESCALE   (PRESCALE),
      .TX_OUT     (TX_OUT),
      .BUSY       (BUSY),
      .FIFO_COUNT (FIFO_COUNT)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // bits: line level per bit period, LSB = start bit.
   typedef struct {
      logic [7:0]  data;
      logic        par_en;
      logic        par_typ;
      logic        stop2;
      int          presc;
      logic [15:0] bits;
      int          nbits;
      int          busy_len;
   } vec_t;

   vec_t vecs [7];
   logic tx_log   [0:599];
   logic busy_log [0:599];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         if (!BUSY && FIFO_COUNT == 3'd0) break;
         tick();
      end
      check("wait_idle", {BUSY, FIFO_COUNT}, 32'd0);
   endtask

   // Waits (bounded) for BUSY, then logs ncyc consecutive cycles starting there.
   task automatic monitor(input int ncyc);
      int w;
      w = 0;
      while (!BUSY && w < 60) begin
         tick();
         w++;
      end
      check("monitor_start", BUSY, 1);
      for (int c = 0; c < ncyc; c++) begin
         tx_log[c]   = TX_OUT;
         busy_log[c] = BUSY;
         tick();
      end
   endtask

   // {stop, data[7:0], start} of a no-parity frame sampled mid-bit.
   function automatic logic [9:0] frame_at(input int base, input int p);
      logic [9:0] f;
      f[0] = tx_log[base + p / 2];
      for (int b = 0; b < 8; b++) begin
         f[b + 1] = tx_log[base + p * (1 + b) + p / 2];
      end
      f[9] = tx_log[base + p * 9 + p / 2];
      return f;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int p;
      int len;
      int errs;
      int busy_n;
      logic exp_tx;
      p        = (v.presc == 0) ? 1 : v.presc;
      len      = p * v.nbits;
      PAR_EN   = v.par_en;
      PAR_TYP  = v.par_typ;
      STOP2    = v.stop2;
      PRESCALE = PW'(v.presc);
      bus.P_DATA     = v.data;
      bus.DATA_VALID = 1'b1;
      tick();
      bus.DATA_VALID = 1'b0;
      check($sformatf("vec%0d_count_after_push", idx), FIFO_COUNT, 1);
      tick();
      check($sformatf("vec%0d_first_start", idx), {BUSY, TX_OUT}, 2'b10);
      errs   = 0;
      busy_n = 0;
      for (int c = 0; c < len + 2; c++) begin
         exp_tx = (c < len) ? v.bits[c / p] : 1'b1;
         if (TX_OUT !== exp_tx) errs++;
         if (BUSY === 1'b1) busy_n++;
         tick();
      end
      check($sformatf("vec%0d_bit_errors", idx), errs, 0);
      check($sformatf("vec%0d_busy_cycles", idx), busy_n, v.busy_len);
   endtask

   initial begin
      logic [7:0]  w6  [6];
      logic [7:0]  w10 [10];
      int          sched [10];
      logic [15:0] f1;
      logic [15:0] f2;
      int          errs;
      int          acc_edge [6];

      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 4, 16'h054A, 11, 44};
      vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 4, 16'h0F4A, 12, 48};
      vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 4, 16'h034A, 10, 40};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 0, 16'h0400, 11, 11};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 2, 16'h07FE, 11, 22};
      vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1, 16'h0C78, 12, 12};
      vecs[6] = '{8'h01, 1'b0, 1'b0, 1'b1, 3, 16'h0602, 11, 33};

      w6    = '{8'h11, 8'h82, 8'h3C, 8'hF0, 8'h5A, 8'hC3};
      w10   = '{8'h07, 8'h24, 8'h41, 8'h5E, 8'h7B, 8'h98, 8'hB5, 8'hD2, 8'hEF, 8'h0C};
      sched = '{0, 1, 2, 11, 21, 31, 41, 51, 61, 71};
      f1    = 16'h054A;
      f2    = 16'h02B4;

      RST            = 1'b1;
      PAR_EN         = 1'b0;
      PAR_TYP        = 1'b0;
      STOP2          = 1'b0;
      PRESCALE       = '0;
      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_tx", TX_OUT, 1);
      check("reset_busy", BUSY, 0);
      check("reset_ready", bus.READY, 1);
      check("reset_count", FIFO_COUNT, 0);
      RST = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], i);
         wait_idle();
      end

      // Reset in the middle of data bit 3 with a second word still queued.
      PRESCALE = 6'd4; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
      bus.P_DATA = 8'hA5; bus.DATA_VALID = 1'b1;
      tick();
      bus.P_DATA = 8'h3C;
      tick();
      bus.DATA_VALID = 1'b0;
      repeat (17) tick();
      check("pre_reset_count", FIFO_COUNT, 1);
      #3 RST = 1'b1;
      #1;
      check("midframe_reset_tx", TX_OUT, 1);
      check("midframe_reset_busy", BUSY, 0);
      check("midframe_reset_count", FIFO_COUNT, 0);
      check("midframe_reset_ready", bus.READY, 1);
      tick();
      RST = 1'b0;
      errs = 0;
      for (int c = 0; c < 60; c++) begin
         if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || FIFO_COUNT !== 3'd0) errs++;
         tick();
      end
      check("post_reset_quiet", errs, 0);

      // FIFO full, back-to-back frames, 40-cycle frames.
      PRESCALE = 6'd4; PAR_EN = 1'b0; STOP2 = 1'b0;
      fork
         begin
            int e;
            int guard;
            logic rdy;
            e = 0;
            for (int i = 0; i < 6; i++) begin
               bus.P_DATA     = w6[i];
               bus.DATA_VALID = 1'b1;
               guard = 0;
               do begin
                  rdy = bus.READY;
                  tick();
                  e++;
                  guard++;
               end while (!rdy && guard < 100);
               acc_edge[i] = e;
               if (i == 4) begin
                  check("full_count", FIFO_COUNT, 4);
                  check("full_ready", bus.READY, 0);
               end
            end
            bus.DATA_VALID = 1'b0;
            check("w5_accept_offset", acc_edge[5] - acc_edge[0], 42);
         end
         begin
            monitor(240);
            check("b2b_idle_after", BUSY, 0);
         end
      join
      for (int j = 0; j < 6; j++) begin
         check($sformatf("b2b_frame%0d", j), frame_at(j * 40, 4), {1'b1, w6[j], 1'b0});
      end
      errs = 0;
      for (int c = 0; c < 240; c++) begin
         if (busy_log[c] !== 1'b1) errs++;
      end
      check("b2b_busy_gaps", errs, 0);
      wait_idle();

      // Config change mid-frame; second frame uses PRESCALE=0, no parity.
      PRESCALE = 6'd4; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
      bus.P_DATA = 8'hA5; bus.DATA_VALID = 1'b1;
      tick();
      bus.DATA_VALID = 1'b0;
      tick();
      errs = 0;
      for (int c = 0; c < 56; c++) begin
         logic et;
         logic eb;
         if (c < 44) begin
            et = f1[c / 4]; eb = 1'b1;
         end else if (c < 54) begin
            et = f2[c - 44]; eb = 1'b1;
         end else begin
            et = 1'b1; eb = 1'b0;
         end
         if (TX_OUT !== et || BUSY !== eb) errs++;
         if (c == 10) begin
            PAR_EN = 1'b0; PAR_TYP = 1'b1; PRESCALE = '0;
            bus.P_DATA = 8'h5A; bus.DATA_VALID = 1'b1;
         end else if (c == 11) begin
            bus.DATA_VALID = 1'b0;
         end
         tick();
      end
      check("cfg_change_errors", errs, 0);
      wait_idle();

      // Push exactly when the last stop bit pops: count holds at 2; pointers wrap.
      PRESCALE = 6'd1; PAR_EN = 1'b0; STOP2 = 1'b0;
      fork
         begin
            int k;
            k = 0;
            for (int e = 0; e < 76; e++) begin
               if (k < 10 && sched[k] == e) begin
                  bus.P_DATA     = w10[k];
                  bus.DATA_VALID = 1'b1;
               end else begin
                  bus.DATA_VALID = 1'b0;
               end
               tick();
               if (bus.DATA_VALID && k < 10) begin
                  if (e >= 11) begin
                     check($sformatf("pushpop_count_e%0d", e), FIFO_COUNT, 2);
                  end
                  k++;
               end
            end
            bus.DATA_VALID = 1'b0;
         end
         begin
            monitor(100);
            check("wrap_idle_after", BUSY, 0);
         end
      join
      for (int j = 0; j < 10; j++) begin
         check($sformatf("wrap_frame%0d", j), frame_at(j * 10, 1), {1'b1, w10[j], 1'b0});
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
